// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station: default sizes,
// micro-op type/opcode encodings and the resolved-operand record.
package rs_alu_pkg;

   localparam int RS_SZ_LOG_DEF  = 4;
   localparam int ROB_SZ_LOG_DEF = 4;

   typedef enum logic [3:0] {
      OPT_CAL  = 4'd0,
      OPT_CALI = 4'd1,
      OPT_BRA  = 4'd2,
      OPT_JUM  = 4'd3
   } optype_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9,
      OP_BEQ  = 4'd10,
      OP_BNE  = 4'd11,
      OP_BLT  = 4'd12,
      OP_BGE  = 4'd13,
      OP_JAL  = 4'd14,
      OP_JALR = 4'd15
   } opcode_e;

   // Operand after CDB resolution: still-pending flag plus current value.
   typedef struct packed {
      logic        pend;
      logic [31:0] val;
   } opnd_t;

endpackage

// File: rtl/rs_alu_pick.sv
// Combinational priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_alu_pick #(
   parameter int N_LOG = 4
) (
   input  logic [2**N_LOG-1:0] i_req,
   output logic                o_found,
   output logic [N_LOG-1:0]    o_idx
);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = 2**N_LOG - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_found = 1'b1;
            o_idx   = N_LOG'(i);
         end
      end
   end

endmodule

// File: rtl/rs_alu.sv
// Reservation station in front of the integer ALU: buffers micro-ops, snoops
// the ALU/LSB result buses for missing operands, dispatches one ready op/cycle.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int RS_SZ_LOG  = RS_SZ_LOG_DEF,
   parameter int ROB_SZ_LOG = ROB_SZ_LOG_DEF
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clr_in,
   input  logic                  issue_flg,
   input  logic [3:0]            issue_opcode,
   input  logic [3:0]            issue_optype,
   input  logic [31:0]           issue_Vj,
   input  logic [31:0]           issue_Vk,
   input  logic                  issue_Qj_flg,
   input  logic                  issue_Qk_flg,
   input  logic [ROB_SZ_LOG:0]   issue_Qj,
   input  logic [ROB_SZ_LOG:0]   issue_Qk,
   input  logic [31:0]           issue_imm,
   input  logic [31:0]           issue_pc,
   input  logic [ROB_SZ_LOG:0]   issue_rd,
   output logic                  full_out,
   input  logic                  alu_cdb_flg,
   input  logic [ROB_SZ_LOG:0]   alu_cdb_tag,
   input  logic [31:0]           alu_cdb_val,
   input  logic                  lsb_cdb_flg,
   input  logic [ROB_SZ_LOG:0]   lsb_cdb_tag,
   input  logic [31:0]           lsb_cdb_val,
   output logic                  run_flg,
   output logic [31:0]           Vj,
   output logic [31:0]           Vk,
   output logic [31:0]           imm,
   output logic [31:0]           pc,
   output logic [3:0]            opcode,
   output logic [3:0]            optype,
   output logic [ROB_SZ_LOG:0]   rd_fr
);

   localparam int N  = 2**RS_SZ_LOG;
   localparam int TW = ROB_SZ_LOG + 1;

   logic [N-1:0]    r_busy;
   logic [N-1:0]    r_qj_flg;
   logic [N-1:0]    r_qk_flg;
   logic [3:0]      r_opcode [N];
   logic [3:0]      r_optype [N];
   logic [31:0]     r_vj     [N];
   logic [31:0]     r_vk     [N];
   logic [31:0]     r_imm    [N];
   logic [31:0]     r_pc     [N];
   logic [TW-1:0]   r_qj     [N];
   logic [TW-1:0]   r_qk     [N];
   logic [TW-1:0]   r_rd     [N];

   opnd_t           w_snp_j  [N];
   opnd_t           w_snp_k  [N];
   logic [N-1:0]    w_ready;
   opnd_t           w_iss_j;
   opnd_t           w_iss_k;
   logic            w_free_found;
   logic [RS_SZ_LOG-1:0] w_free_idx;
   logic            w_rdy_found;
   logic [RS_SZ_LOG-1:0] w_rdy_idx;

   // ALU bus wins over LSB bus; a double match carries identical data anyway.
   function automatic opnd_t cdb_resolve(input logic pend, input logic [TW-1:0] tag,
                                         input logic [31:0] val);
      opnd_t res;
      res.pend = pend;
      res.val  = val;
      if (pend && alu_cdb_flg && (alu_cdb_tag == tag)) begin
         res.pend = 1'b0;
         res.val  = alu_cdb_val;
      end else if (pend && lsb_cdb_flg && (lsb_cdb_tag == tag)) begin
         res.pend = 1'b0;
         res.val  = lsb_cdb_val;
      end
      return res;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_entry
         assign w_snp_j[gi] = cdb_resolve(r_qj_flg[gi], r_qj[gi], r_vj[gi]);
         assign w_snp_k[gi] = cdb_resolve(r_qk_flg[gi], r_qk[gi], r_vk[gi]);
         assign w_ready[gi] = r_busy[gi] & ~r_qj_flg[gi] & ~r_qk_flg[gi];
      end
   endgenerate

   assign w_iss_j  = cdb_resolve(issue_Qj_flg, issue_Qj, issue_Vj);
   assign w_iss_k  = cdb_resolve(issue_Qk_flg, issue_Qk, issue_Vk);
   assign full_out = &r_busy;

   rs_alu_pick #(.N_LOG(RS_SZ_LOG)) u_pick_free (
      .i_req   (~r_busy),
      .o_found (w_free_found),
      .o_idx   (w_free_idx)
   );

   rs_alu_pick #(.N_LOG(RS_SZ_LOG)) u_pick_ready (
      .i_req   (w_ready),
      .o_found (w_rdy_found),
      .o_idx   (w_rdy_idx)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_busy   <= '0;
         r_qj_flg <= '0;
         r_qk_flg <= '0;
         for (int i = 0; i < N; i++) begin
            r_opcode[i] <= '0;
            r_optype[i] <= '0;
            r_vj[i]     <= '0;
            r_vk[i]     <= '0;
            r_imm[i]    <= '0;
            r_pc[i]     <= '0;
            r_qj[i]     <= '0;
            r_qk[i]     <= '0;
            r_rd[i]     <= '0;
         end
         run_flg <= 1'b0;
         Vj      <= '0;
         Vk      <= '0;
         imm     <= '0;
         pc      <= '0;
         opcode  <= '0;
         optype  <= '0;
         rd_fr   <= '0;
      end else if (!rdy_in) begin
         run_flg <= 1'b0;
      end else if (clr_in) begin
         r_busy  <= '0;
         run_flg <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (r_busy[i]) begin
               r_qj_flg[i] <= w_snp_j[i].pend;
               r_vj[i]     <= w_snp_j[i].val;
               r_qk_flg[i] <= w_snp_k[i].pend;
               r_vk[i]     <= w_snp_k[i].val;
            end
         end

         if (w_rdy_found) begin
            run_flg           <= 1'b1;
            Vj                <= r_vj[w_rdy_idx];
            Vk                <= r_vk[w_rdy_idx];
            imm               <= r_imm[w_rdy_idx];
            pc                <= r_pc[w_rdy_idx];
            opcode            <= r_opcode[w_rdy_idx];
            optype            <= r_optype[w_rdy_idx];
            rd_fr             <= r_rd[w_rdy_idx];
            r_busy[w_rdy_idx] <= 1'b0;
         end else begin
            run_flg <= 1'b0;
         end

         // The free slot is never the dispatched one, so both writes can coexist.
         if (issue_flg && w_free_found) begin
            r_busy[w_free_idx]   <= 1'b1;
            r_opcode[w_free_idx] <= issue_opcode;
            r_optype[w_free_idx] <= issue_optype;
            r_qj_flg[w_free_idx] <= w_iss_j.pend;
            r_vj[w_free_idx]     <= w_iss_j.val;
            r_qk_flg[w_free_idx] <= w_iss_k.pend;
            r_vk[w_free_idx]     <= w_iss_k.val;
            r_qj[w_free_idx]     <= issue_Qj;
            r_qk[w_free_idx]     <= issue_Qk;
            r_imm[w_free_idx]    <= issue_imm;
            r_pc[w_free_idx]     <= issue_pc;
            r_rd[w_free_idx]     <= issue_rd;
         end
      end
   end

endmodule
